// File: rtl/boss_proj_manager.sv
// Five-slot boss projectile manager: spawns, moves and retires projectiles and detects player hits.
// Optional post-hit invulnerability counter is enabled by defining HIT_INVULN_EN.
module boss_proj_manager #(
    parameter int unsigned PROJ_SPEED   = 4,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PROJ_W       = 10,
    parameter int unsigned PROJ_H       = 15,
    parameter int unsigned PLAYER_W     = 30,
    parameter int unsigned PLAYER_H     = 20,
    parameter int unsigned INVULN_TICKS = 16
) (
    input  logic       clk_master,
    input  logic       rst,
    input  logic       pulse_move,
    input  logic       bossShoot,
    input  logic [9:0] spawn1X,
    input  logic [9:0] spawn2X,
    input  logic [9:0] spawn3X,
    input  logic [9:0] spawn4X,
    input  logic [9:0] spawn5X,
    input  logic [8:0] spawn1Y,
    input  logic [8:0] spawn2Y,
    input  logic [8:0] spawn3Y,
    input  logic [8:0] spawn4Y,
    input  logic [8:0] spawn5Y,
    input  logic [9:0] playerX,
    input  logic [8:0] playerY,
    output logic [4:0] projActive,
    output logic [9:0] proj1X,
    output logic [9:0] proj2X,
    output logic [9:0] proj3X,
    output logic [9:0] proj4X,
    output logic [9:0] proj5X,
    output logic [8:0] proj1Y,
    output logic [8:0] proj2Y,
    output logic [8:0] proj3Y,
    output logic [8:0] proj4Y,
    output logic [8:0] proj5Y,
    output logic       playerHit
);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q [5];
    logic [9:0]  x_d [5];
    logic [8:0]  y_q [5];
    logic [8:0]  y_d [5];
    logic [4:0]  act_q, act_d;
    logic        hit_q, hit_d;
    logic        blocked;

    logic [9:0]  sx [5];
    logic [8:0]  sy [5];
    logic [9:0]  sum [5];
    logic [4:0]  ovl;

    assign sx[0] = spawn1X;  assign sy[0] = spawn1Y;
    assign sx[1] = spawn2X;  assign sy[1] = spawn2Y;
    assign sx[2] = spawn3X;  assign sy[2] = spawn3Y;
    assign sx[3] = spawn4X;  assign sy[3] = spawn4Y;
    assign sx[4] = spawn5X;  assign sy[4] = spawn5Y;

    // Move sum is 10 bits wide so a slot near the bottom cannot wrap back to the top.
    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            sum[i] = {1'b0, y_q[i]} + 10'(PROJ_SPEED);
            ovl[i] = ({1'b0, x_q[i]} < {1'b0, playerX} + 11'(PLAYER_W)) &&
                     ({1'b0, playerX} < {1'b0, x_q[i]} + 11'(PROJ_W)) &&
                     ({2'b0, y_q[i]} < {2'b0, playerY} + 11'(PLAYER_H)) &&
                     ({2'b0, playerY} < {2'b0, y_q[i]} + 11'(PROJ_H));
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        act_d   = act_q;
        hit_d   = 1'b0;
        if (bossShoot) begin
            for (int unsigned i = 0; i < 5; i++) begin
                x_d[i]   = sx[i];
                y_d[i]   = sy[i];
                act_d[i] = (sx[i] != '0) || (sy[i] != '0);
            end
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (pulse_move) state_d = MOVE;
                MOVE: begin
                    for (int unsigned i = 0; i < 5; i++) begin
                        if (act_q[i]) begin
                            if (sum[i] >= 10'(SCREEN_H)) act_d[i] = 1'b0;
                            else                         y_d[i]   = sum[i][8:0];
                        end
                    end
                    state_d = CHECK;
                end
                CHECK: begin
                    act_d   = act_q & ~ovl;
                    hit_d   = ((act_q & ovl) != '0) && !blocked;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef HIT_INVULN_EN
    logic [4:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hit_d)                          cnt_d = 5'(INVULN_TICKS);
        else if (pulse_move && cnt_q != '0) cnt_d = cnt_q - 5'd1;
    end

    assign blocked = (cnt_q != '0);

    always_ff @(posedge clk_master) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign blocked = 1'b0;
`endif

    always_ff @(posedge clk_master) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            hit_q   <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            for (int unsigned i = 0; i < 5; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign projActive = act_q;
    assign playerHit  = hit_q;
    assign proj1X = x_q[0];  assign proj1Y = y_q[0];
    assign proj2X = x_q[1];  assign proj2Y = y_q[1];
    assign proj3X = x_q[2];  assign proj3Y = y_q[2];
    assign proj4X = x_q[3];  assign proj4Y = y_q[3];
    assign proj5X = x_q[4];  assign proj5Y = y_q[4];

endmodule

// File: tb/tb_boss_proj_manager.sv
// Directed self-checking bench for boss_proj_manager; expectations depend on HIT_INVULN_EN.
module tb_boss_proj_manager;

    logic       clk_master = 1'b0;
    logic       rst        = 1'b1;
    logic       pulse_move = 1'b0;
    logic       bossShoot  = 1'b0;
    logic [9:0] sx [5];
    logic [8:0] sy [5];
    logic [9:0] playerX = '0;
    logic [8:0] playerY = '0;
    logic [4:0] projActive;
    logic [9:0] px [5];
    logic [8:0] py [5];
    logic       playerHit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_master = ~clk_master;

    boss_proj_manager dut (
        .clk_master (clk_master),
        .rst        (rst),
        .pulse_move (pulse_move),
        .bossShoot  (bossShoot),
        .spawn1X    (sx[0]), .spawn2X (sx[1]), .spawn3X (sx[2]), .spawn4X (sx[3]), .spawn5X (sx[4]),
        .spawn1Y    (sy[0]), .spawn2Y (sy[1]), .spawn3Y (sy[2]), .spawn4Y (sy[3]), .spawn5Y (sy[4]),
        .playerX    (playerX),
        .playerY    (playerY),
        .projActive (projActive),
        .proj1X     (px[0]), .proj2X (px[1]), .proj3X (px[2]), .proj4X (px[3]), .proj5X (px[4]),
        .proj1Y     (py[0]), .proj2Y (py[1]), .proj3Y (py[2]), .proj4Y (py[3]), .proj5Y (py[4]),
        .playerHit  (playerHit)
    );

    task automatic tick();
        @(posedge clk_master);
        #1;
    endtask

    task automatic clear_spawns();
        for (int i = 0; i < 5; i++) begin
            sx[i] = '0;
            sy[i] = '0;
        end
    endtask

    task automatic shoot();
        bossShoot = 1'b1;
        tick();
        bossShoot = 1'b0;
    endtask

    // One move tick; returns playerHit as seen on the second edge after the pulse.
    task automatic do_move(output logic h);
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        tick();
        tick();
        h = playerHit;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            sx[i] = 10'd100 + 10'(i);
            sy[i] = 9'd50;
        end
        rst = 1'b1; bossShoot = 1'b1; pulse_move = 1'b1;
        tick(); tick();
        n_cmp++;
        if (projActive !== 5'b00000) begin
            n_bad++; $display("FAIL reset_active got %b exp 00000", projActive);
        end
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL reset_hit got %b exp 0", playerHit);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (px[i] !== 10'd0 || py[i] !== 9'd0) begin
                n_bad++; $display("FAIL reset_pos%0d got (%0d,%0d) exp (0,0)", i + 1, px[i], py[i]);
            end
        end
        rst = 1'b0; bossShoot = 1'b0; pulse_move = 1'b0;
        tick();
    endtask

    task automatic test_spawn();
        int ex [5] = '{145, 230, 315, 400, 485};
        playerX = 10'd0; playerY = 9'd0;
        for (int i = 0; i < 5; i++) begin
            sx[i] = 10'(ex[i]);
            sy[i] = 9'd200;
        end
        shoot();
        n_cmp++;
        if (projActive !== 5'b11111) begin
            n_bad++; $display("FAIL spawn_active got %b exp 11111", projActive);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (px[i] !== 10'(ex[i]) || py[i] !== 9'd200) begin
                n_bad++; $display("FAIL spawn_pos%0d got (%0d,%0d) exp (%0d,200)", i + 1, px[i], py[i], ex[i]);
            end
        end
    endtask

    task automatic test_move();
        logic h;
        sx[4] = '0; sy[4] = '0;
        shoot();
        n_cmp++;
        if (projActive !== 5'b01111) begin
            n_bad++; $display("FAIL move_zero_spawn got %b exp 01111", projActive);
        end
        for (int k = 0; k < 3; k++) begin
            do_move(h);
            n_cmp++;
            if (h !== 1'b0) begin
                n_bad++; $display("FAIL move_nohit%0d got %b exp 0", k, h);
            end
        end
        n_cmp++;
        if (projActive !== 5'b01111) begin
            n_bad++; $display("FAIL move_active got %b exp 01111", projActive);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (py[i] !== 9'd212) begin
                n_bad++; $display("FAIL move_y%0d got %0d exp 212", i + 1, py[i]);
            end
        end
        n_cmp++;
        if (px[4] !== 10'd0 || py[4] !== 9'd0) begin
            n_bad++; $display("FAIL move_slot5_hold got (%0d,%0d) exp (0,0)", px[4], py[4]);
        end
    endtask

    task automatic test_retire();
        logic h;
        clear_spawns();
        sx[0] = 10'd145; sy[0] = 9'd476;
        sx[1] = 10'd230; sy[1] = 9'd475;
        shoot();
        do_move(h);
        n_cmp++;
        if (projActive !== 5'b00010) begin
            n_bad++; $display("FAIL retire_active got %b exp 00010", projActive);
        end
        n_cmp++;
        if (py[0] !== 9'd476) begin
            n_bad++; $display("FAIL retire_hold_y got %0d exp 476", py[0]);
        end
        n_cmp++;
        if (py[1] !== 9'd479) begin
            n_bad++; $display("FAIL retire_edge_y got %0d exp 479", py[1]);
        end
        n_cmp++;
        if (h !== 1'b0) begin
            n_bad++; $display("FAIL retire_nohit got %b exp 0", h);
        end
    endtask

    task automatic test_hit();
        playerX = 10'd228; playerY = 9'd300;
        clear_spawns();
        sx[0] = 10'd600; sy[0] = 9'd296;
        sx[1] = 10'd230; sy[1] = 9'd296;
        sx[2] = 10'd235; sy[2] = 9'd296;
        shoot();
        // Spawned on top of the player: no hit until a move has happened.
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (playerHit !== 1'b0) begin
                n_bad++; $display("FAIL hit_spawn_idle%0d got %b exp 0", k, playerHit);
            end
        end
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL hit_early1 got %b exp 0", playerHit);
        end
        tick();
        n_cmp++;
        if (playerHit !== 1'b0 || py[1] !== 9'd300 || py[2] !== 9'd300) begin
            n_bad++; $display("FAIL hit_early2 got hit=%b y2=%0d y3=%0d exp hit=0 y=300", playerHit, py[1], py[2]);
        end
        tick();
        n_cmp++;
        if (playerHit !== 1'b1) begin
            n_bad++; $display("FAIL hit_pulse got %b exp 1", playerHit);
        end
        n_cmp++;
        if (projActive !== 5'b00001) begin
            n_bad++; $display("FAIL hit_deactivate got %b exp 00001", projActive);
        end
        tick();
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL hit_one_cycle got %b exp 0", playerHit);
        end
    endtask

    task automatic test_same_cycle();
        clear_spawns();
        sx[0] = 10'd230; sy[0] = 9'd296;
        sx[1] = 10'd400; sy[1] = 9'd100;
        pulse_move = 1'b1; bossShoot = 1'b1;
        tick();
        pulse_move = 1'b0; bossShoot = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (playerHit !== 1'b0) begin
                n_bad++; $display("FAIL same_nohit%0d got %b exp 0", k, playerHit);
            end
        end
        n_cmp++;
        if (projActive !== 5'b00011 || py[0] !== 9'd296 || py[1] !== 9'd100 || px[1] !== 10'd400) begin
            n_bad++; $display("FAIL same_spawn got act=%b y1=%0d y2=%0d x2=%0d exp act=00011 y1=296 y2=100 x2=400",
                              projActive, py[0], py[1], px[1]);
        end
    endtask

    task automatic test_shoot_cancels_check();
        shoot();
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        tick();
        bossShoot = 1'b1;
        tick();
        bossShoot = 1'b0;
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL cancel_nohit got %b exp 0", playerHit);
        end
        n_cmp++;
        if (projActive !== 5'b00011 || py[0] !== 9'd296) begin
            n_bad++; $display("FAIL cancel_reload got act=%b y1=%0d exp act=00011 y1=296", projActive, py[0]);
        end
        tick();
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL cancel_nohit_late got %b exp 0", playerHit);
        end
    endtask

    task automatic test_back_to_back();
        logic h;
        playerX = 10'd0; playerY = 9'd0;
        clear_spawns();
        sx[0] = 10'd145; sy[0] = 9'd100;
        shoot();
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        tick();
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (py[0] !== 9'd104) begin
            n_bad++; $display("FAIL b2b_check_ignored got %0d exp 104", py[0]);
        end
        do_move(h);
        n_cmp++;
        if (py[0] !== 9'd108 || projActive !== 5'b00001) begin
            n_bad++; $display("FAIL b2b_next_move got y=%0d act=%b exp y=108 act=00001", py[0], projActive);
        end
    endtask

    task automatic test_reset_abort();
        playerX = 10'd228; playerY = 9'd300;
        clear_spawns();
        sx[0] = 10'd230; sy[0] = 9'd296;
        shoot();
        pulse_move = 1'b1;
        tick();
        pulse_move = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (playerHit !== 1'b0 || projActive !== 5'b00000 || py[0] !== 9'd0) begin
            n_bad++; $display("FAIL abort_reset got hit=%b act=%b y=%0d exp 0/00000/0", playerHit, projActive, py[0]);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (playerHit !== 1'b0) begin
            n_bad++; $display("FAIL abort_nohit got %b exp 0", playerHit);
        end
    endtask

    task automatic test_invuln();
        logic h;
        logic exp_second;
`ifdef HIT_INVULN_EN
        exp_second = 1'b0;
`else
        exp_second = 1'b1;
`endif
        playerX = 10'd228; playerY = 9'd300;
        clear_spawns();
        sx[0] = 10'd230; sy[0] = 9'd296;
        shoot();
        do_move(h);
        n_cmp++;
        if (h !== 1'b1) begin
            n_bad++; $display("FAIL inv_first_hit got %b exp 1", h);
        end
        shoot();
        do_move(h);
        n_cmp++;
        if (h !== exp_second) begin
            n_bad++; $display("FAIL inv_second_hit got %b exp %b", h, exp_second);
        end
        n_cmp++;
        if (projActive !== 5'b00000) begin
            n_bad++; $display("FAIL inv_second_deact got %b exp 00000", projActive);
        end
        // 14 idle ticks bring the total since the first hit to 15; the next overlap's own tick makes 16.
        for (int k = 0; k < 14; k++) do_move(h);
        shoot();
        do_move(h);
        n_cmp++;
        if (h !== 1'b1) begin
            n_bad++; $display("FAIL inv_third_hit got %b exp 1", h);
        end
    endtask

    initial begin
        clear_spawns();
        test_reset();
        test_spawn();
        test_move();
        test_retire();
        test_hit();
        test_same_cycle();
        test_shoot_cancels_check();
        test_back_to_back();
        test_reset_abort();
        test_invuln();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
